gtp_tx_framer: RTL and testbench

Transmit-side packet framer for the GTP/Aurora link. It reads a payload from the local packet buffer RAM and serialises it onto the AXI4-Stream TX interface as a CRC-protected frame: 0xFFBC, ID, header, data, CRC, 0xFFBD. It also emits two-word trigger frames. Its output format is exactly what the link-partner receiver's `gtp_rx` parses.

---
 rtl/gtp_pkg.sv | 39 +++
 rtl/gtp_tx_skid_fifo.sv | 48 ++++
 rtl/gtp_tx_framer.sv | 152 +++++++++++++++
 tb/tb_gtp_tx_framer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gtp_pkg.sv
// Shared definitions for the GTP/Aurora framing link: control words,
// CRC seed, transmit state encoding and the 32-bit parallel CRC-32 step
// that both the transmitter and the receiver use.
package gtp_pkg;

    localparam logic [31:0] SOF_WORD   = 32'h0000_FFBC;
    localparam logic [31:0] EOF_WORD   = 32'h0000_FFBD;
    localparam logic [31:0] TRIG0_WORD = 32'h0000_FFBA;
    localparam logic [31:0] TRIG1_WORD = 32'h0000_FFBB;

    localparam logic [31:0] CRC_SEED = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SOF,
        ST_ID,
        ST_HDR,
        ST_DATA,
        ST_CRC,
        ST_EOF,
        ST_TRIG0,
        ST_TRIG1
    } tx_state_e;

    // One CRC-32 step over a full word, MSB first, no reflection.
    function automatic logic [31:0] nextCRC32_D32(input logic [31:0] data,
                                                  input logic [31:0] crc);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 31; i >= 0; i--) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
        end
        return c;
    endfunction

endpackage

// File: rtl/gtp_tx_skid_fifo.sv
// Two-entry, 32-bit skid FIFO holding prefetched packet-buffer words.
// The level output lets the framer throttle reads including in-flight ones.
module gtp_tx_skid_fifo (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  logic [31:0] wdata_i,
    input  logic        pop_i,
    output logic [31:0] rdata_o,
    output logic        empty_o,
    output logic [1:0]  level_o
);

    logic [31:0] mem_q [2];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  level_q, level_d;
    logic        push_ok, pop_ok;

    assign empty_o = (level_q == 2'd0);
    assign push_ok = push_i && (level_q != 2'd2);
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Occupancy after this cycle's push and pop.
    always_comb begin
        level_d = level_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            level_q  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr_q <= ~wr_ptr_q;
            if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
            level_q <= level_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/gtp_tx_framer.sv
// Transmit framer: serialises SOF, ID, header, payload, CRC and EOF words
// (or a two-word trigger frame) onto the AXI4-Stream TX port, prefetching
// payload from the packet buffer into a small skid FIFO.
module gtp_tx_framer
    import gtp_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1   // in-flight accounting assumes a latency of 1
) (
    input  logic              log_clk,
    input  logic              log_rst_n,
    input  logic              tx_start,
    input  logic [7:0]        tx_head,
    input  logic [7:0]        tx_length,
    input  logic              tx_trigger,
    input  logic [31:0]       gtx_id,
    output logic              packet_data_rd_en,
    output logic [ADDR_W-1:0] packet_data_rd_addr,
    input  logic [31:0]       packet_data_rdata,
    output logic [31:0]       s_axi_tx_tdata,
    output logic              s_axi_tx_tvalid,
    output logic              s_axi_tx_tlast,
    input  logic              s_axi_tx_tready,
    output logic              tx_busy,
    output logic              tx_done
);

    tx_state_e         state_q, state_d;
    logic [7:0]        head_q, len_q, data_left_q, rd_left_q;
    logic [31:0]       id_q, crc_q;
    logic              trig_pend_q, tx_done_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [RD_LAT-1:0] rd_pipe_q;

    logic              hs, go_trig, accept, rd_state, inflight;
    logic              fifo_pop, fifo_empty;
    logic [1:0]        fifo_level;
    logic [31:0]       fifo_rdata;
    logic [2:0]        occ_after;

    assign hs       = s_axi_tx_tvalid && s_axi_tx_tready;
    assign go_trig  = trig_pend_q || tx_trigger;
    assign accept   = (state_q == ST_IDLE) && !go_trig && tx_start;
    assign rd_state = state_q inside {ST_SOF, ST_ID, ST_HDR, ST_DATA};
    assign inflight = |rd_pipe_q;
    assign fifo_pop = (state_q == ST_DATA) && hs;

    // Slots the FIFO would hold once every issued read lands, net of this cycle's pop.
    assign occ_after = 3'(fifo_level) + 3'(inflight) - 3'(fifo_pop);

    assign packet_data_rd_en   = rd_state && (rd_left_q != 8'd0) && (occ_after < 3'd2);
    assign packet_data_rd_addr = rd_addr_q;
    assign tx_done             = tx_done_q;

    gtp_tx_skid_fifo u_fifo (
        .clk_i   (log_clk),
        .rst_ni  (log_rst_n),
        .push_i  (rd_pipe_q[RD_LAT-1]),
        .wdata_i (packet_data_rdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // State register.
    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // Next-state: triggers win in IDLE, every other state advances on a handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (go_trig)       state_d = ST_TRIG0;
                else if (tx_start) state_d = ST_SOF;
            end
            ST_SOF:   if (hs) state_d = ST_ID;
            ST_ID:    if (hs) state_d = ST_HDR;
            ST_HDR:   if (hs) state_d = (len_q == 8'd0) ? ST_CRC : ST_DATA;
            ST_DATA:  if (hs && data_left_q == 8'd1) state_d = ST_CRC;
            ST_CRC:   if (hs) state_d = ST_EOF;
            ST_EOF:   if (hs) state_d = ST_IDLE;
            ST_TRIG0: if (hs) state_d = ST_TRIG1;
            ST_TRIG1: if (hs) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Stream outputs are decoded from registered state so they hold while stalled.
    always_comb begin
        s_axi_tx_tvalid = 1'b0;
        s_axi_tx_tdata  = 32'h0;
        s_axi_tx_tlast  = 1'b0;
        tx_busy         = (state_q != ST_IDLE);
        unique case (state_q)
            ST_SOF:   begin s_axi_tx_tvalid = 1'b1; s_axi_tx_tdata = SOF_WORD; end
            ST_ID:    begin s_axi_tx_tvalid = 1'b1; s_axi_tx_tdata = id_q; end
            ST_HDR:   begin s_axi_tx_tvalid = 1'b1; s_axi_tx_tdata = {16'h0, head_q, len_q}; end
            ST_DATA:  begin s_axi_tx_tvalid = !fifo_empty; s_axi_tx_tdata = fifo_rdata; end
            ST_CRC:   begin s_axi_tx_tvalid = 1'b1; s_axi_tx_tdata = crc_q; end
            ST_EOF:   begin s_axi_tx_tvalid = 1'b1; s_axi_tx_tdata = EOF_WORD;   s_axi_tx_tlast = 1'b1; end
            ST_TRIG0: begin s_axi_tx_tvalid = 1'b1; s_axi_tx_tdata = TRIG0_WORD; end
            ST_TRIG1: begin s_axi_tx_tvalid = 1'b1; s_axi_tx_tdata = TRIG1_WORD; s_axi_tx_tlast = 1'b1; end
            default:  ;
        endcase
    end

    // Frame context, CRC, read pointer/counters and the pending-trigger flag.
    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            head_q      <= 8'h0;
            len_q       <= 8'h0;
            id_q        <= 32'h0;
            crc_q       <= CRC_SEED;
            data_left_q <= 8'h0;
            rd_left_q   <= 8'h0;
            rd_addr_q   <= '0;
            rd_pipe_q   <= '0;
            trig_pend_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            rd_pipe_q <= (rd_pipe_q << 1) | RD_LAT'(packet_data_rd_en);
            tx_done_q <= (state_q == ST_EOF) && hs;

            if (state_q == ST_IDLE && go_trig) trig_pend_q <= 1'b0;
            else if (tx_trigger)               trig_pend_q <= 1'b1;

            if (accept) begin
                head_q      <= tx_head;
                len_q       <= tx_length;
                id_q        <= gtx_id;
                crc_q       <= CRC_SEED;
                data_left_q <= tx_length;
                rd_left_q   <= tx_length;
                rd_addr_q   <= ADDR_W'(tx_head);
            end else begin
                if (hs && (state_q inside {ST_ID, ST_HDR, ST_DATA}))
                    crc_q <= nextCRC32_D32(s_axi_tx_tdata, crc_q);
                if (fifo_pop)
                    data_left_q <= data_left_q - 8'd1;
                if (packet_data_rd_en) begin
                    rd_left_q <= rd_left_q - 8'd1;
                    rd_addr_q <= rd_addr_q + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_gtp_tx_framer.sv
// Directed bench for gtp_tx_framer with a word-queue frame model and a
// per-cycle stream checker.
module tb_gtp_tx_framer;

    localparam logic [31:0] W_SOF  = 32'h0000FFBC;
    localparam logic [31:0] W_EOF  = 32'h0000FFBD;
    localparam logic [31:0] W_TRG0 = 32'h0000FFBA;
    localparam logic [31:0] W_TRG1 = 32'h0000FFBB;
    localparam logic [31:0] M_POLY = 32'h04C11DB7;

    logic        log_clk = 1'b0;
    logic        log_rst_n = 1'b1;
    logic        tx_start, tx_trigger;
    logic [7:0]  tx_head, tx_length;
    logic [31:0] gtx_id;
    logic        packet_data_rd_en;
    logic [7:0]  packet_data_rd_addr;
    logic [31:0] packet_data_rdata = 32'h0;
    logic [31:0] s_axi_tx_tdata;
    logic        s_axi_tx_tvalid, s_axi_tx_tlast;
    logic        s_axi_tx_tready = 1'b1;
    logic        tx_busy, tx_done;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        bp_on = 1'b0;
    logic [31:0] mem [0:255];
    logic [32:0] exp_q [$];
    logic [7:0]  rd_log [$];

    gtp_tx_framer dut (
        .log_clk             (log_clk),
        .log_rst_n           (log_rst_n),
        .tx_start            (tx_start),
        .tx_head             (tx_head),
        .tx_length           (tx_length),
        .tx_trigger          (tx_trigger),
        .gtx_id              (gtx_id),
        .packet_data_rd_en   (packet_data_rd_en),
        .packet_data_rd_addr (packet_data_rd_addr),
        .packet_data_rdata   (packet_data_rdata),
        .s_axi_tx_tdata      (s_axi_tx_tdata),
        .s_axi_tx_tvalid     (s_axi_tx_tvalid),
        .s_axi_tx_tlast      (s_axi_tx_tlast),
        .s_axi_tx_tready     (s_axi_tx_tready),
        .tx_busy             (tx_busy),
        .tx_done             (tx_done)
    );

    initial forever #5 log_clk = ~log_clk;
    initial forever begin @(posedge log_clk); cyc++; end

    // Packet buffer: one-cycle registered read.
    always @(posedge log_clk) if (packet_data_rd_en) packet_data_rdata <= mem[packet_data_rd_addr];

    // Ready driver: always ready, or coin-flip backpressure.
    initial forever begin
        @(posedge log_clk); #1;
        s_axi_tx_tready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    // CRC model: fold the word into the register, then clock 32 zero bits through.
    function automatic logic [31:0] m_crc(input logic [31:0] crc, input logic [31:0] d);
        logic [31:0] x;
        x = crc ^ d;
        repeat (32) x = x[31] ? ((x << 1) ^ M_POLY) : (x << 1);
        return x;
    endfunction

    task automatic queue_frame(input logic [7:0] head, input logic [7:0] len, input logic [31:0] id);
        logic [31:0] crc, w;
        logic [7:0]  a;
        crc = 32'hFFFFFFFF;
        exp_q.push_back({1'b0, W_SOF});
        exp_q.push_back({1'b0, id});
        crc = m_crc(crc, id);
        w = {16'h0, head, len};
        exp_q.push_back({1'b0, w});
        crc = m_crc(crc, w);
        for (int i = 0; i < int'(len); i++) begin
            a = head + 8'(i);
            w = mem[a];
            exp_q.push_back({1'b0, w});
            crc = m_crc(crc, w);
        end
        exp_q.push_back({1'b0, crc});
        exp_q.push_back({1'b1, W_EOF});
    endtask

    task automatic queue_trig();
        exp_q.push_back({1'b0, W_TRG0});
        exp_q.push_back({1'b1, W_TRG1});
    endtask

    task automatic start_frame(input logic [7:0] h, input logic [7:0] l, input logic [31:0] id,
                               input logic trig);
        tx_head = h; tx_length = l; gtx_id = id; tx_start = 1'b1; tx_trigger = trig;
        @(posedge log_clk); #1;
        tx_start = 1'b0; tx_trigger = 1'b0;
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_busy) && n < limit) begin
            @(negedge log_clk);
            n++;
        end
        chk({name, "_drain_left"}, 33'(exp_q.size()), 33'd0);
        repeat (3) @(posedge log_clk);
        #1;
    endtask

    // Per-cycle stream checker against the expected word queue.
    initial begin
        logic        hold_v, end_pend, end_data;
        logic [32:0] hold_w, w;
        hold_v = 1'b0; end_pend = 1'b0; end_data = 1'b0; hold_w = '0;
        forever begin
            @(negedge log_clk);
            if (!log_rst_n) begin
                hold_v = 1'b0; end_pend = 1'b0;
                continue;
            end
            chk("tx_done", 33'(tx_done), 33'(end_pend && end_data));
            if (end_pend) chk("busy_after_last", 33'(tx_busy), 33'd0);
            end_pend = 1'b0;
            if (hold_v)
                chk("hold", {s_axi_tx_tvalid, s_axi_tx_tlast, s_axi_tx_tdata},
                    {1'b1, hold_w});
            if (s_axi_tx_tvalid && s_axi_tx_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {s_axi_tx_tlast, s_axi_tx_tdata}, 33'h1_DEADDEAD);
                end else begin
                    w = exp_q.pop_front();
                    chk("word", {s_axi_tx_tlast, s_axi_tx_tdata}, w);
                    if (w[32]) begin
                        end_pend = 1'b1;
                        end_data = (w[31:0] == W_EOF);
                    end
                end
            end
            hold_v = s_axi_tx_tvalid && !s_axi_tx_tready;
            hold_w = {s_axi_tx_tlast, s_axi_tx_tdata};
        end
    end

    // Read-address log for the wrap test.
    initial forever begin
        @(negedge log_clk);
        if (log_rst_n && packet_data_rd_en) rd_log.push_back(packet_data_rd_addr);
    end

    initial begin
        int t0, n;
        tx_start = 1'b0; tx_trigger = 1'b0; tx_head = 8'h0; tx_length = 8'h0; gtx_id = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = {8'(i), 8'(255 - i), 8'(i * 3), 8'h5C};
        mem[8'h10] = 32'hA5A5A5A5;
        mem[8'h11] = 32'h5A5A5A5A;

        // Hand-computed CRC model pins.
        chk("model_crc_1", 33'(m_crc(32'h0, 32'h1)), 33'h004C11DB7);
        chk("model_crc_2", 33'(m_crc(32'h0, 32'h2)), 33'h009823B6E);
        chk("model_crc_3", 33'(m_crc(32'h0, 32'h3)), 33'(32'h04C11DB7 ^ 32'h09823B6E));

        // Reset state.
        #2 log_rst_n = 1'b0;
        #1;
        chk("rst_tvalid", 33'(s_axi_tx_tvalid), 33'd0);
        chk("rst_tdata",  33'(s_axi_tx_tdata),  33'd0);
        chk("rst_tlast",  33'(s_axi_tx_tlast),  33'd0);
        chk("rst_busy",   33'(tx_busy),         33'd0);
        chk("rst_done",   33'(tx_done),         33'd0);
        chk("rst_rd_en",  33'(packet_data_rd_en), 33'd0);
        repeat (3) @(posedge log_clk);
        #1 log_rst_n = 1'b1;
        repeat (2) @(posedge log_clk);
        #1;

        // Basic frame with literal word pins on the model.
        queue_frame(8'h10, 8'd2, 32'h12345678);
        chk("model_id",  exp_q[1], {1'b0, 32'h12345678});
        chk("model_hdr", exp_q[2], {1'b0, 32'h00001002});
        chk("model_d0",  exp_q[3], {1'b0, 32'hA5A5A5A5});
        chk("model_d1",  exp_q[4], {1'b0, 32'h5A5A5A5A});
        start_frame(8'h10, 8'd2, 32'h12345678, 1'b0);
        t0 = cyc;
        chk("sof_busy",  33'(tx_busy),         33'd1);
        chk("sof_valid", 33'(s_axi_tx_tvalid), 33'd1);
        chk("sof_data",  33'(s_axi_tx_tdata),  33'(W_SOF));
        n = 0;
        while (!tx_done && n < 50) begin @(negedge log_clk); n++; end
        chk("basic_cycles", 33'(cyc - t0), 33'd7);

        // Back-to-back: start in the tx_done cycle.
        queue_frame(8'h11, 8'd1, 32'h0BADBEEF);
        tx_head = 8'h11; tx_length = 8'd1; gtx_id = 32'h0BADBEEF; tx_start = 1'b1;
        @(posedge log_clk); #1;
        tx_start = 1'b0;
        chk("b2b_sof", {s_axi_tx_tvalid, s_axi_tx_tdata}, {1'b1, W_SOF});
        drain("b2b", 60);

        // Zero length.
        queue_frame(8'h33, 8'd0, 32'hCAFEF00D);
        chk("model_hdr0", exp_q[2], {1'b0, 32'h00003300});
        start_frame(8'h33, 8'd0, 32'hCAFEF00D, 1'b0);
        drain("zero_len", 60);

        // Address wrap.
        rd_log.delete();
        queue_frame(8'hFE, 8'd4, 32'h0000A0A0);
        start_frame(8'hFE, 8'd4, 32'h0000A0A0, 1'b0);
        drain("wrap", 60);
        chk("wrap_nreads", 33'(rd_log.size()), 33'd4);
        if (rd_log.size() == 4) begin
            chk("wrap_a0", 33'(rd_log[0]), 33'h0FE);
            chk("wrap_a1", 33'(rd_log[1]), 33'h0FF);
            chk("wrap_a2", 33'(rd_log[2]), 33'h000);
            chk("wrap_a3", 33'(rd_log[3]), 33'h001);
        end

        // Length 8 without and with backpressure.
        queue_frame(8'h40, 8'd8, 32'h13579BDF);
        start_frame(8'h40, 8'd8, 32'h13579BDF, 1'b0);
        drain("len8", 80);
        bp_on = 1'b1;
        queue_frame(8'h40, 8'd8, 32'h13579BDF);
        start_frame(8'h40, 8'd8, 32'h13579BDF, 1'b0);
        drain("len8_bp", 400);
        queue_frame(8'hFD, 8'd5, 32'h2468ACE0);
        start_frame(8'hFD, 8'd5, 32'h2468ACE0, 1'b0);
        drain("len5_bp", 400);
        bp_on = 1'b0;
        repeat (2) @(posedge log_clk);
        #1;

        // Two trigger pulses and an ignored start during a frame.
        queue_frame(8'h20, 8'd4, 32'h11112222);
        queue_trig();
        start_frame(8'h20, 8'd4, 32'h11112222, 1'b0);
        @(posedge log_clk); #1 tx_trigger = 1'b1;
        @(posedge log_clk); #1 tx_trigger = 1'b0; tx_start = 1'b1; tx_head = 8'h77;
        @(posedge log_clk); #1 tx_start = 1'b0; tx_trigger = 1'b1;
        @(posedge log_clk); #1 tx_trigger = 1'b0;
        drain("trig_during", 80);
        repeat (8) @(posedge log_clk);
        #1;

        // Start and trigger together in IDLE: trigger frame only.
        queue_trig();
        start_frame(8'h50, 8'd3, 32'h99999999, 1'b1);
        drain("start_and_trig", 40);
        repeat (10) @(posedge log_clk);
        #1;

        // Mid-frame reset during DATA.
        queue_frame(8'h80, 8'd8, 32'h55AA55AA);
        start_frame(8'h80, 8'd8, 32'h55AA55AA, 1'b0);
        repeat (4) @(posedge log_clk);
        #2 log_rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", 33'(s_axi_tx_tvalid), 33'd0);
        chk("mid_rst_tdata",  33'(s_axi_tx_tdata),  33'd0);
        chk("mid_rst_tlast",  33'(s_axi_tx_tlast),  33'd0);
        chk("mid_rst_busy",   33'(tx_busy),         33'd0);
        chk("mid_rst_rd_en",  33'(packet_data_rd_en), 33'd0);
        chk("mid_rst_rd_addr", 33'(packet_data_rd_addr), 33'd0);
        exp_q.delete();
        repeat (2) @(posedge log_clk);
        #1 log_rst_n = 1'b1;
        @(posedge log_clk); #1;
        queue_frame(8'h90, 8'd3, 32'h76543210);
        start_frame(8'h90, 8'd3, 32'h76543210, 1'b0);
        drain("post_rst", 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: time=%0t limit=200000", $time);
        $fatal(1, "watchdog");
    end

endmodule
